demux_registrado: RTL and testbench

Parametrised 1-to-N demultiplexer with registered outputs and per-channel valid/ready flow control. It is the generalisation of the team's combinational 4-way demux.
- Each output channel holds one word in its own register until the consumer accepts it.
- Out-of-range selectors are detected and counted instead of silently driving an output.
- Sits between a single producer stream and N consumer lanes in the datapath.

---
 rtl/demux_registrado_pkg.sv | 19 +
 rtl/demux_canal.sv | 50 +++++
 rtl/demux_registrado.sv | 102 ++++++++++
 tb/tb_demux_registrado.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/demux_registrado_pkg.sv
// Shared defaults and helpers for the registered 1-to-N demultiplexer.
`ifndef DEMUX_REGISTRADO_PKG_SV
`define DEMUX_REGISTRADO_PKG_SV

package demux_registrado_pkg;

    // Default geometry of the block
    localparam int DATA_BITS_DEF   = 4;
    localparam int NUM_SALIDAS_DEF = 4;
    localparam int CNT_BITS_DEF    = 8;

    // Selector width for n channels; never narrower than one bit
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`endif

// File: rtl/demux_canal.sv
// One output lane: a single-word holding register with its valid flag.
// The lane can take a new word when empty, or when full and its consumer
// drains it in the same cycle (pass-through refill, no bubble).
module demux_canal #(
    parameter int DATA_BITS = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cargar,
    input  logic [DATA_BITS-1:0] dato,
    input  logic                 listo,
    output logic [DATA_BITS-1:0] dato_canal,
    output logic                 valido,
    output logic                 puede_tomar
);

    logic [DATA_BITS-1:0] dato_reg;
    logic [DATA_BITS-1:0] dato_next;
    logic                 valido_reg;
    logic                 valido_next;

    // Next-state: a load wins over a drain; data holds while empty
    always_comb begin
        dato_next   = dato_reg;
        valido_next = valido_reg;
        if (cargar) begin
            dato_next   = dato;
            valido_next = 1'b1;
        end else if (valido_reg && listo) begin
            valido_next = 1'b0;
        end
    end

    // Lane state register; reset discards the held word outright
    always_ff @(posedge clk) begin
        if (reset) begin
            dato_reg   <= '0;
            valido_reg <= 1'b0;
        end else begin
            dato_reg   <= dato_next;
            valido_reg <= valido_next;
        end
    end

    assign dato_canal  = dato_reg;
    assign valido      = valido_reg;
    // Ready may depend combinationally on the consumer, never the reverse
    assign puede_tomar = !valido_reg || listo;

endmodule

// File: rtl/demux_registrado.sv
// Registered 1-to-N demultiplexer with per-lane valid/ready flow control.
// Words addressed to a lane that does not exist are swallowed, counted in a
// saturating drop counter and flagged with a sticky error bit.
module demux_registrado
    import demux_registrado_pkg::*;
#(
    parameter int  DATA_BITS   = DATA_BITS_DEF,
    parameter int  NUM_SALIDAS = NUM_SALIDAS_DEF,
    parameter int  CNT_BITS    = CNT_BITS_DEF,
    localparam int SEL_BITS    = sel_width(NUM_SALIDAS)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             enb,
    input  logic [DATA_BITS-1:0]             entrada,
    input  logic [SEL_BITS-1:0]              selector,
    input  logic                             valido_entrada,
    output logic                             listo_entrada,
    output logic [NUM_SALIDAS*DATA_BITS-1:0] salidas,
    output logic [NUM_SALIDAS-1:0]           validos_salida,
    input  logic [NUM_SALIDAS-1:0]           listos_salida,
    output logic                             error_sel,
    output logic [CNT_BITS-1:0]              contador_descartes
);

    // Channel count widened by one bit so the range test never truncates
    localparam logic [SEL_BITS:0]   NUM_SAL_W = (SEL_BITS + 1)'(NUM_SALIDAS);
    localparam logic [CNT_BITS-1:0] CNT_MAX   = '1;

    logic                   sel_ok;
    logic                   puede_sel;
    logic                   transfiere;
    logic                   descarta;
    logic [NUM_SALIDAS-1:0] sel_onehot;
    logic [NUM_SALIDAS-1:0] puede_vec;
    logic [NUM_SALIDAS-1:0] carga_vec;

    logic                   error_sel_reg;
    logic                   error_sel_next;
    logic [CNT_BITS-1:0]    contador_reg;
    logic [CNT_BITS-1:0]    contador_next;

    // Only meaningful when the channel count is not a power of two
    assign sel_ok = ({1'b0, selector} < NUM_SAL_W);

    // Decode the selector into one load strobe per existing lane
    genvar gi;
    generate
        for (gi = 0; gi < NUM_SALIDAS; gi++) begin : g_canal
            assign sel_onehot[gi] = (selector == SEL_BITS'(gi));
            assign carga_vec[gi]  = transfiere && sel_onehot[gi];

            demux_canal #(
                .DATA_BITS (DATA_BITS)
            ) u_canal (
                .clk         (clk),
                .reset       (reset),
                .cargar      (carga_vec[gi]),
                .dato        (entrada),
                .listo       (listos_salida[gi]),
                .dato_canal  (salidas[gi*DATA_BITS +: DATA_BITS]),
                .valido      (validos_salida[gi]),
                .puede_tomar (puede_vec[gi])
            );
        end
    endgenerate

    // Can-take of the addressed lane; zero when no lane matches
    assign puede_sel = |(puede_vec & sel_onehot);

    // A bad selector is always accepted so the producer never stalls on it
    assign listo_entrada = enb && (sel_ok ? puede_sel : 1'b1);
    assign transfiere    = valido_entrada && listo_entrada && sel_ok;
    assign descarta      = valido_entrada && enb && !sel_ok;

    // Drop bookkeeping: sticky flag and saturating counter
    always_comb begin
        error_sel_next = error_sel_reg;
        contador_next  = contador_reg;
        if (descarta) begin
            error_sel_next = 1'b1;
            if (contador_reg != CNT_MAX) begin
                contador_next = contador_reg + 1'b1;
            end
        end
    end

    // Drop bookkeeping registers
    always_ff @(posedge clk) begin
        if (reset) begin
            error_sel_reg <= 1'b0;
            contador_reg  <= '0;
        end else begin
            error_sel_reg <= error_sel_next;
            contador_reg  <= contador_next;
        end
    end

    assign error_sel          = error_sel_reg;
    assign contador_descartes = contador_reg;

endmodule

// File: tb/tb_demux_registrado.sv
// Directed bench: a 4-lane instance for routing/flow control and a 3-lane,
// 2-bit-counter instance for out-of-range selectors and counter saturation.
module tb_demux_registrado;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // 4-lane instance
    logic        enb, valido_entrada, listo_entrada, error_sel;
    logic [3:0]  entrada, validos_salida, listos_salida;
    logic [1:0]  selector;
    logic [15:0] salidas;
    logic [7:0]  contador_descartes;

    // 3-lane instance
    logic        enb3, valido_entrada3, listo_entrada3, error_sel3;
    logic [3:0]  entrada3;
    logic [1:0]  selector3, contador_descartes3;
    logic [2:0]  validos_salida3, listos_salida3;
    logic [11:0] salidas3;

    int checks = 0;
    int errors = 0;

    demux_registrado #(.DATA_BITS(4), .NUM_SALIDAS(4), .CNT_BITS(8)) u_dut (
        .clk(clk), .reset(reset), .enb(enb), .entrada(entrada),
        .selector(selector), .valido_entrada(valido_entrada),
        .listo_entrada(listo_entrada), .salidas(salidas),
        .validos_salida(validos_salida), .listos_salida(listos_salida),
        .error_sel(error_sel), .contador_descartes(contador_descartes)
    );

    demux_registrado #(.DATA_BITS(4), .NUM_SALIDAS(3), .CNT_BITS(2)) u_dut3 (
        .clk(clk), .reset(reset), .enb(enb3), .entrada(entrada3),
        .selector(selector3), .valido_entrada(valido_entrada3),
        .listo_entrada(listo_entrada3), .salidas(salidas3),
        .validos_salida(validos_salida3), .listos_salida(listos_salida3),
        .error_sel(error_sel3), .contador_descartes(contador_descartes3)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle 1 ns past it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        enb = 0; valido_entrada = 0; entrada = 0; selector = 0; listos_salida = 0;
        enb3 = 0; valido_entrada3 = 0; entrada3 = 0; selector3 = 0; listos_salida3 = 0;
        tick();
        tick();
        check("rst_salidas", salidas, 16'h0000);
        check("rst_validos", validos_salida, 4'b0000);
        check("rst_error", error_sel, 1'b0);
        check("rst_cnt", contador_descartes, 8'd0);
        check("rst_listo", listo_entrada, 1'b0);
        check("rst3_validos", validos_salida3, 3'b000);
        check("rst3_cnt", contador_descartes3, 2'd0);
        $display("reset: validos=%b salidas=%h", validos_salida, salidas);

        // 1. Basic routing
        reset = 0; enb = 1; listos_salida = 4'b1111;
        entrada = 4'hA; selector = 2; valido_entrada = 1;
        #1 check("route_listo", listo_entrada, 1'b1);
        tick();
        check("route_A_validos", validos_salida, 4'b0100);
        check("route_A_salidas", salidas, 16'h0A00);
        $display("route A->2: validos=%b salidas=%h", validos_salida, salidas);
        entrada = 4'h5; selector = 0;
        tick();
        check("route_5_validos", validos_salida, 4'b0001);
        check("route_5_salidas", salidas, 16'h0A05);
        $display("route 5->0: validos=%b salidas=%h", validos_salida, salidas);
        valido_entrada = 0;
        tick();
        check("route_drained", validos_salida, 4'b0000);

        // 2. Backpressure and pass-through refill on lane 1
        listos_salida = 4'b1101;
        entrada = 4'h3; selector = 1; valido_entrada = 1;
        tick();
        check("bp_3_validos", validos_salida, 4'b0010);
        check("bp_3_salidas", salidas, 16'h0A35);
        entrada = 4'h7;
        #1 check("bp_listo_low", listo_entrada, 1'b0);
        tick();
        check("bp_hold_salidas", salidas, 16'h0A35);
        check("bp_hold_validos", validos_salida, 4'b0010);
        listos_salida = 4'b1111;
        #1 check("bp_listo_high", listo_entrada, 1'b1);
        tick();
        check("bp_refill_salidas", salidas, 16'h0A75);
        check("bp_refill_validos", validos_salida, 4'b0010);
        $display("backpressure refill: validos=%b salidas=%h", validos_salida, salidas);
        valido_entrada = 0;
        tick();
        check("bp_drained", validos_salida, 4'b0000);

        // 3. Concurrent drain of lanes 0 and 3 with refill of lane 3
        listos_salida = 4'b0000; valido_entrada = 1;
        entrada = 4'h1; selector = 0;
        tick();
        entrada = 4'h2; selector = 3;
        tick();
        check("conc_full", validos_salida, 4'b1001);
        check("conc_full_salidas", salidas, 16'h2A71);
        listos_salida = 4'b1001; entrada = 4'h9; selector = 3;
        #1 check("conc_listo", listo_entrada, 1'b1);
        tick();
        check("conc_validos", validos_salida, 4'b1000);
        check("conc_salidas", salidas, 16'h9A71);
        $display("concurrency: validos=%b salidas=%h", validos_salida, salidas);
        valido_entrada = 0; listos_salida = 4'b0000;

        // 5. enb low on the 4-lane instance: no accept, drain still works
        enb = 0; valido_entrada = 1; entrada = 4'hF; selector = 1;
        #1 check("enb_listo", listo_entrada, 1'b0);
        tick();
        check("enb_validos", validos_salida, 4'b1000);
        check("enb_salidas", salidas, 16'h9A71);
        listos_salida = 4'b1000;
        tick();
        check("enb_drain", validos_salida, 4'b0000);
        check("enb_cnt", contador_descartes, 8'd0);
        $display("enb low: validos=%b salidas=%h", validos_salida, salidas);
        valido_entrada = 0; listos_salida = 4'b0000; enb = 1;

        // 4. Out-of-range selector on the 3-lane instance, counter saturates at 3
        enb3 = 1; listos_salida3 = 3'b111; valido_entrada3 = 1; entrada3 = 4'h8; selector3 = 3;
        for (int i = 1; i <= 5; i++) begin
            #1 check("oor_listo", listo_entrada3, 1'b1);
            tick();
            check("oor_cnt", contador_descartes3, (i > 3) ? 2'd3 : 2'(i));
            check("oor_error", error_sel3, 1'b1);
            check("oor_validos", validos_salida3, 3'b000);
            $display("oor word %0d: cnt=%0d error=%b validos=%b", i, contador_descartes3, error_sel3, validos_salida3);
        end
        check("oor_salidas", salidas3, 12'h000);

        // 5b. enb low with a bad selector does not count
        enb3 = 0;
        #1 check("enb3_listo", listo_entrada3, 1'b0);
        tick();
        check("enb3_cnt", contador_descartes3, 2'd3);
        // Park a word in lane 2 of the 3-lane instance
        enb3 = 1; listos_salida3 = 3'b000; entrada3 = 4'h4; selector3 = 2;
        tick();
        check("l3_validos", validos_salida3, 3'b100);
        check("l3_salidas", salidas3, 12'h400);
        valido_entrada3 = 0;

        // 6. Fill all four lanes, then reset mid-operation
        valido_entrada = 1;
        for (int k = 0; k < 4; k++) begin
            selector = 2'(k);
            entrada = 4'(4'hB + k);
            tick();
        end
        valido_entrada = 0;
        check("fill_validos", validos_salida, 4'b1111);
        check("fill_salidas", salidas, 16'hEDCB);
        reset = 1;
        tick();
        reset = 0;
        check("mid_rst_validos", validos_salida, 4'b0000);
        check("mid_rst_salidas", salidas, 16'h0000);
        check("mid_rst3_validos", validos_salida3, 3'b000);
        check("mid_rst3_salidas", salidas3, 12'h000);
        check("mid_rst3_error", error_sel3, 1'b0);
        check("mid_rst3_cnt", contador_descartes3, 2'd0);
        $display("mid reset: validos=%b error3=%b cnt3=%0d", validos_salida, error_sel3, contador_descartes3);
        entrada = 4'h6; selector = 1; valido_entrada = 1;
        tick();
        valido_entrada = 0;
        check("post_rst_validos", validos_salida, 4'b0010);
        check("post_rst_salidas", salidas, 16'h0060);
        $display("post reset 6->1: validos=%b salidas=%h", validos_salida, salidas);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
